seg_scan_scheduler: RTL
=======================

Name: seg_scan_scheduler

Overview:
- Time-multiplexes the shared BCD-to-7-segment decoder across four common-anode digits on the parking display.
- Accepts a binary free-space count through a valid/ready handshake and converts it to BCD with a sequential double-dabble engine.
- Commits each converted result to the display atomically.
- Scans the digits at a fixed rate, with leading-zero blanking, an inter-digit ghosting guard and an optional blink used for the "lot full" indication.

Parameters:
- VAL_W, 10, width of the binary input value; legal range 4..13, so the maximum value is 8191 and fits in 4 digits.
- SCAN_DIV, 50000, clock cycles each digit stays selected; minimum 4.
- GUARD, 2, cycles at the start of each digit slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64, full 4-digit frames per blink half-period.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- upd_valid  input  1  new value offered
- upd_value  input  VAL_W  binary value to display
- upd_ready  output  1  scheduler can accept a value
- blank_en  input  1  enable leading-zero blanking
- blink_en  input  1  enable display blink
- bcd_out  output  4  nibble to the decoder; bit3 = A (MSB) through bit0 = D
- an_n  output  4  active-low digit anodes; bit0 = units digit
- digit_sel  output  2  index of the digit currently scanned
- busy  output  1  conversion in progress

Behaviour:
- Reset, asynchronous on rst_n low, applies immediately:
  - Display register holds BCD 0000.
  - bcd_out = 0, an_n = 4'b1111, digit_sel = 0, busy = 0, upd_ready = 1.
  - Scan, guard and blink counters are cleared.
  - Reset asserted mid-conversion discards the in-flight value.
- Conversion FSM has three states, IDLE, SHIFT and COMMIT:
  - IDLE: upd_ready = 1. When upd_valid & upd_ready on a clock edge, capture upd_value, clear the BCD accumulator, set shift count = VAL_W, and go to SHIFT.
  - SHIFT: upd_ready = 0, busy = 1. Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the count. When the count reaches 0, go to COMMIT.
  - COMMIT: write the accumulator to the display register, busy = 0, go to IDLE. upd_ready returns to 1 in the cycle after COMMIT.
  - Accept-to-commit latency is VAL_W + 1 cycles. The new value is visible on the next digit slot boundary.
  - upd_valid while busy is ignored; the requester must hold the value until the handshake completes.
- Scan:
  - The slot counter counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and digit_sel increments mod 4; 3 wraps to 0.
  - bcd_out and an_n are registered, with one cycle of latency from the digit_sel change.
  - bcd_out = display nibble[digit_sel].
  - For slot counter < GUARD: an_n = 4'b1111.
  - Otherwise: an_n is one-hot-low on digit_sel, unless the digit is blanked or in the blink off phase.
- Blanking, when blank_en = 1:
  - Digit k (k = 1..3) is blanked if it and every higher digit are zero. A blanked digit has its anode held high.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_en = 0 shows all four digits.
- Blink:
  - A frame counter increments each time digit_sel wraps 3->0. Each time it reaches BLINK_FRAMES-1, the phase toggles and the counter resets.
  - Off phase with blink_en = 1: an_n = 4'b1111.
  - With blink_en = 0 the phase is forced to on and the counter is held at 0, so blink always starts in the on phase.
- Display register update is atomic: a COMMIT never mixes old and new digits within one frame's nibble source.
- Simultaneous events:
  - COMMIT and a slot boundary in the same cycle: the new digit is shown.
  - A handshake on the cycle after COMMIT is accepted normally.

Test Plan (bench uses SCAN_DIV = 8, GUARD = 2, BLINK_FRAMES = 2):
- Reset release, no update -> an_n low only on bit0 in slots of digit 0 (cycles 2..7 of slot); bcd_out = 0; digits 1-3 blanked with blank_en = 1.
- Update 1234 (VAL_W = 13) -> busy high 13 cycles, commit at accept+14; the following frame scans bcd_out 4, 3, 2, 1 with an_n 1110, 1101, 1011, 0111.
- Update 7 with blank_en = 1 -> only digit 0 lit showing 7; with blank_en = 0 -> digits show 0, 0, 0, 7, all anodes active.
- upd_valid held continuously with value 99 then 100 -> second value accepted only after upd_ready returns; display goes 99 -> 100, never shows a partial value such as 199.
- blink_en = 1 -> anodes on for 2 frames (64 cycles), all-off for 2 frames, repeating; deassert -> anodes on next slot.
- rst_n pulsed low mid-SHIFT of value 500 -> outputs return to reset values asynchronously; after release the display shows 0 and upd_ready = 1.

Source files
------------

// File: rtl/seg_scan_scheduler_if.sv
// Update handshake and scanned-display bus of the parking display scheduler.
// The master side drives updates and display options; the slave side is the scheduler.
interface seg_scan_scheduler_if #(
  parameter int unsigned VAL_W = 10
);
  logic             upd_valid;
  logic [VAL_W-1:0] upd_value;
  logic             upd_ready;
  logic             blank_en;
  logic             blink_en;
  logic [3:0]       bcd_out;
  logic [3:0]       an_n;
  logic [1:0]       digit_sel;
  logic             busy;

  modport master (
    output upd_valid, upd_value, blank_en, blink_en,
    input  upd_ready, bcd_out, an_n, digit_sel, busy
  );

  modport slave (
    input  upd_valid, upd_value, blank_en, blink_en,
    output upd_ready, bcd_out, an_n, digit_sel, busy
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Four-digit common-anode scan scheduler with a sequential double-dabble converter,
// leading-zero blanking, inter-digit ghosting guard and frame-based blink.
module seg_scan_scheduler #(
  parameter int unsigned VAL_W        = 10,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic                clk,
  input logic                rst_n,
  seg_scan_scheduler_if.slave bus
);

  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W   = $clog2(VAL_W + 1);
  localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e             state_q;
  logic [15:0]        acc_bcd_q;
  logic [VAL_W-1:0]   acc_bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        disp_q;
  logic               ready_q;
  logic               busy_q;

  logic [SLOT_W-1:0]  slot_q;
  logic [1:0]         digit_sel_q;
  logic [FRAME_W-1:0] frame_q;
  logic               blink_off_q;
  logic [3:0]         bcd_q;
  logic [3:0]         an_q;
  logic               dark_q;

  logic [15:0]        bcd_adj;
  logic [3:0]         blank_vec;
  logic               last_slot;
  logic               slot_start;
  logic               frame_wrap;
  logic               dark_comb;
  logic               dark_now;
  logic [3:0]         onehot;

  // Add-3 correction applied before each shift of the double-dabble engine.
  always_comb begin
    bcd_adj = acc_bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = acc_bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_bcd_q <= '0;
      acc_bin_q <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.upd_valid && ready_q) begin
            acc_bin_q <= bus.upd_value;
            acc_bcd_q <= '0;
            cnt_q     <= CNT_W'(VAL_W);
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          acc_bcd_q <= {bcd_adj[14:0], acc_bin_q[VAL_W-1]};
          acc_bin_q <= {acc_bin_q[VAL_W-2:0], 1'b0};
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= StCommit;
          end
        end
        StCommit: begin
          disp_q  <= acc_bcd_q;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = bus.blank_en && (disp_q[15:12] == 4'd0);
    blank_vec[2] = blank_vec[3] && (disp_q[11:8] == 4'd0);
    blank_vec[1] = blank_vec[2] && (disp_q[7:4] == 4'd0);
  end

  assign last_slot  = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign slot_start = (slot_q == '0);
  assign frame_wrap = last_slot && (digit_sel_q == 2'd3);
  assign dark_comb  = blank_vec[digit_sel_q] || (bus.blink_en && blink_off_q);
  // Blank/blink decision is frozen for the whole slot so a mid-slot commit cannot flicker it.
  assign dark_now   = slot_start ? dark_comb : dark_q;
  assign onehot     = 4'b0001 << digit_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      digit_sel_q <= 2'd0;
      frame_q     <= '0;
      blink_off_q <= 1'b0;
      bcd_q       <= 4'd0;
      an_q        <= 4'hF;
      dark_q      <= 1'b0;
    end else begin
      slot_q <= last_slot ? '0 : slot_q + SLOT_W'(1);
      if (last_slot) begin
        digit_sel_q <= digit_sel_q + 2'd1;
      end

      if (!bus.blink_en) begin
        frame_q     <= '0;
        blink_off_q <= 1'b0;
      end else if (frame_wrap) begin
        if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_q     <= '0;
          blink_off_q <= ~blink_off_q;
        end else begin
          frame_q <= frame_q + FRAME_W'(1);
        end
      end

      // Nibble source is sampled once per slot, so a commit lands on the next slot boundary.
      if (slot_start) begin
        bcd_q  <= disp_q[4*digit_sel_q +: 4];
        dark_q <= dark_comb;
      end

      if ((slot_q < SLOT_W'(GUARD)) || dark_now) begin
        an_q <= 4'hF;
      end else begin
        an_q <= ~onehot;
      end
    end
  end

  assign bus.upd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.an_n      = an_q;
  assign bus.digit_sel = digit_sel_q;

endmodule
